// File: rtl/cpu6502_pkg.sv
// cpu6502_pkg: shared definitions for the 6502 core.
//   - P register bit positions (P_C .. P_N)
//   - flag_op encodings for the explicit flag instructions
//   - P_RESET: status register value seen on the push path after reset
package cpu6502_pkg;

    localparam int P_C = 0;
    localparam int P_Z = 1;
    localparam int P_I = 2;
    localparam int P_D = 3;
    localparam int P_B = 4;
    localparam int P_U = 5;
    localparam int P_V = 6;
    localparam int P_N = 7;

    localparam logic [7:0] P_RESET = 8'h34;

    typedef enum logic [2:0] {
        FOP_NONE = 3'b000,
        FOP_CLC  = 3'b001,
        FOP_SEC  = 3'b010,
        FOP_CLI  = 3'b011,
        FOP_SEI  = 3'b100,
        FOP_CLD  = 3'b101,
        FOP_SED  = 3'b110,
        FOP_CLV  = 3'b111
    } flag_op_e;

endpackage

// File: rtl/bcd_nibble_adj.sv
// bcd_nibble_adj: combinational decimal correction of one result nibble.
// Ports:
//   nib_i  - raw binary nibble from the ALU
//   cy_i   - carry out of this nibble (half-carry for low, carry for high)
//   sub_i  - 0: ADC correction, 1: SBC correction
//   nib_o  - corrected nibble (mod 16, no carry into the next nibble)
module bcd_nibble_adj (
    input  logic [3:0] nib_i,
    input  logic       cy_i,
    input  logic       sub_i,
    output logic [3:0] nib_o
);

    logic [3:0] corr;

    // ADC adds 6 when the nibble overflowed past 9; SBC adds 0xA (i.e. -6)
    // when the nibble borrowed (carry clear).
    always_comb begin
        corr = 4'h0;
        if (sub_i) begin
            corr = cy_i ? 4'h0 : 4'hA;
        end else begin
            corr = cy_i ? 4'h6 : 4'h0;
        end
    end

    assign nib_o = nib_i + corr;

endmodule

// File: rtl/alu_flags_6502.sv
// alu_flags_6502: post-ALU stage of the 6502 core. Applies the BCD result
// correction, registers the adjusted result and holds the status register P.
// Configuration macro: BCD_ADJUST_EN (defined = decimal correction enabled;
// undefined = 2A03-style, result passes through unchanged, D still stored).
// Ports:
//   clk, reset_n           - clock, async active-low reset
//   RDY                    - stall: low holds all state
//   alu_out, alu_co/v/n/hc - registered ALU result and flags
//   adj_add, adj_sub       - result is decimal ADC / SBC
//   upd_nz/c/v, upd_bit    - flag write strobes from the ALU result / BIT
//   flag_op                - explicit flag instruction
//   ld_p, db_in            - load P from the data bus (PLP/RTI)
//   php_brk                - B bit presented on p_out
//   res_out                - adjusted registered result
//   p_out                  - {N,V,1,B,D,I,Z,C}
//   flag_c..flag_n         - stored flags
module alu_flags_6502
    import cpu6502_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       RDY,
    input  logic [7:0] alu_out,
    input  logic       alu_co,
    input  logic       alu_v,
    input  logic       alu_n,
    input  logic       alu_hc,
    input  logic       adj_add,
    input  logic       adj_sub,
    input  logic       upd_nz,
    input  logic       upd_c,
    input  logic       upd_v,
    input  logic       upd_bit,
    input  logic [2:0] flag_op,
    input  logic       ld_p,
    input  logic [7:0] db_in,
    input  logic       php_brk,
    output logic [7:0] res_out,
    output logic [7:0] p_out,
    output logic       flag_c,
    output logic       flag_z,
    output logic       flag_i,
    output logic       flag_d,
    output logic       flag_v,
    output logic       flag_n
);

    logic [7:0] res_d, res_q;
    logic       c_d, z_d, i_d, d_d, v_d, n_d;
    logic       c_q, z_q, i_q, d_q, v_q, n_q;
    flag_op_e   fop;

    assign fop = flag_op_e'(flag_op);

`ifdef BCD_ADJUST_EN
    logic [3:0] lo_adj, hi_adj;
    logic       adj_en, adj_is_sub;

    // Both strobes high is treated as ADC.
    assign adj_en     = adj_add | adj_sub;
    assign adj_is_sub = adj_sub & ~adj_add;

    bcd_nibble_adj u_adj_lo (
        .nib_i (alu_out[3:0]),
        .cy_i  (alu_hc),
        .sub_i (adj_is_sub),
        .nib_o (lo_adj)
    );

    bcd_nibble_adj u_adj_hi (
        .nib_i (alu_out[7:4]),
        .cy_i  (alu_co),
        .sub_i (adj_is_sub),
        .nib_o (hi_adj)
    );

    assign res_d = adj_en ? {hi_adj, lo_adj} : alu_out;
`else
    logic unused_adj;
    assign unused_adj = adj_add ^ adj_sub ^ alu_hc;
    assign res_d      = alu_out;
`endif

    // The ALU's own N flag is superseded by the adjusted result's bit 7.
    logic unused_alu_n;
    assign unused_alu_n = alu_n;

    // Per-flag next state: ld_p > flag_op > upd_bit > upd_* > hold.
    always_comb begin
        c_d = c_q;
        z_d = z_q;
        i_d = i_q;
        d_d = d_q;
        v_d = v_q;
        n_d = n_q;
        if (ld_p) begin
            c_d = db_in[P_C];
            z_d = db_in[P_Z];
            i_d = db_in[P_I];
            d_d = db_in[P_D];
            v_d = db_in[P_V];
            n_d = db_in[P_N];
        end else begin
            case (fop)
                FOP_CLC: c_d = 1'b0;
                FOP_SEC: c_d = 1'b1;
                FOP_CLI: i_d = 1'b0;
                FOP_SEI: i_d = 1'b1;
                FOP_CLD: d_d = 1'b0;
                FOP_SED: d_d = 1'b1;
                FOP_CLV: v_d = 1'b0;
                default: ;
            endcase
            if (fop != FOP_CLC && fop != FOP_SEC && upd_c) begin
                c_d = alu_co;
            end
            if (fop != FOP_CLV) begin
                if (upd_bit) begin
                    v_d = db_in[P_V];
                end else if (upd_v) begin
                    v_d = alu_v;
                end
            end
            if (upd_bit) begin
                n_d = db_in[P_N];
                z_d = (res_d == 8'h00);
            end else if (upd_nz) begin
                n_d = res_d[7];
                z_d = (res_d == 8'h00);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_q <= 8'h00;
            c_q   <= P_RESET[P_C];
            z_q   <= P_RESET[P_Z];
            i_q   <= P_RESET[P_I];
            d_q   <= P_RESET[P_D];
            v_q   <= P_RESET[P_V];
            n_q   <= P_RESET[P_N];
        end else if (RDY) begin
            res_q <= res_d;
            c_q   <= c_d;
            z_q   <= z_d;
            i_q   <= i_d;
            d_q   <= d_d;
            v_q   <= v_d;
            n_q   <= n_d;
        end
    end

    assign res_out = res_q;
    assign flag_c  = c_q;
    assign flag_z  = z_q;
    assign flag_i  = i_q;
    assign flag_d  = d_q;
    assign flag_v  = v_q;
    assign flag_n  = n_q;
    assign p_out   = {n_q, v_q, 1'b1, php_brk, d_q, i_q, z_q, c_q};

endmodule
